// File: rtl/mem_access_unit.sv
// Load/store bus access unit for the M stage: turns a legal load or store into one
// request/acknowledge bus transaction, stalling the pipeline until the result is back.
module mem_access_unit #(
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [2:0]  funct3M,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        ExcM,
    output logic        BusErrM
);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    function automatic logic [3:0] byte_enables(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] w;
        case (f3[1:0])
            2'b00:   w = {4{d[7:0]}};
            2'b01:   w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    // Pick the addressed lane out of the returned word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] rd);
        logic [31:0] sh;
        logic [15:0] half;
        logic [31:0] res;
        sh   = rd >> {off, 3'b000};
        half = off[1] ? rd[31:16] : rd[15:0];
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b100:  res = {24'd0, sh[7:0]};
            3'b001:  res = {{16{half[15]}}, half};
            3'b101:  res = {16'd0, half};
            default: res = rd;
        endcase
        return res;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [2:0]  f3_r;
    logic [1:0]  off_r;
    logic [7:0]  cnt_r;
    logic [31:0] read_data_r;
    logic        bus_err_r;
    logic        bus_req_r, bus_we_r;
    logic [31:0] bus_addr_r, bus_wdata_r;
    logic [3:0]  bus_be_r;
    logic        en_s, legal_s, start_s, exc_s, ack_s, timeout_s;

    // Decode whether the presented access size and alignment are supported.
    always_comb begin
        legal_s = 1'b0;
        case (funct3M)
            3'b000, 3'b100: legal_s = 1'b1;
            3'b001, 3'b101: legal_s = ~ALUResultM[0];
            3'b010:         legal_s = (ALUResultM[1:0] == 2'b00);
            default:        legal_s = 1'b0;
        endcase
    end

    assign en_s      = MemReadM | MemWriteM;
    assign start_s   = (state_r == IDLE) && en_s && legal_s;
    assign exc_s     = (state_r == IDLE) && en_s && !legal_s;
    assign ack_s     = (state_r == BUSY) && bus_ack;
    // Counter starts at zero in the first BUSY cycle, so TIMEOUT-1 marks the last one.
    assign timeout_s = (state_r == BUSY) && (TIMEOUT != 8'd0) && (cnt_r == TIMEOUT - 8'd1);

    // Next-state selection for the access sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_nxt_s = BUSY;
                else         state_nxt_s = IDLE;
            end
            BUSY: begin
                if (ack_s || timeout_s) state_nxt_s = DONE;
                else                    state_nxt_s = BUSY;
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_r <= IDLE;
        else        state_r <= state_nxt_s;
    end

    // Bus request registers, BUSY counter and load result capture.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus_req_r   <= 1'b0;
            bus_we_r    <= 1'b0;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 32'd0;
            bus_be_r    <= 4'd0;
            f3_r        <= 3'd0;
            off_r       <= 2'd0;
            cnt_r       <= 8'd0;
            read_data_r <= 32'd0;
            bus_err_r   <= 1'b0;
        end else begin
            bus_err_r <= timeout_s && !ack_s;
            if (start_s) begin
                bus_req_r   <= 1'b1;
                bus_we_r    <= MemWriteM;
                bus_addr_r  <= {ALUResultM[31:2], 2'b00};
                bus_be_r    <= byte_enables(funct3M, ALUResultM[1:0]);
                bus_wdata_r <= lane_data(funct3M, WriteDataM);
                f3_r        <= funct3M;
                off_r       <= ALUResultM[1:0];
                cnt_r       <= 8'd0;
            end else if (state_r == BUSY) begin
                cnt_r <= cnt_r + 8'd1;
                if (ack_s || timeout_s) bus_req_r <= 1'b0;
                if (ack_s) begin
                    if (!bus_we_r) read_data_r <= load_extend(f3_r, off_r, bus_rdata);
                end else if (timeout_s) begin
                    read_data_r <= 32'd0;
                end
            end
        end
    end

    assign bus_req   = bus_req_r;
    assign bus_we    = bus_we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_be    = bus_be_r;
    assign ReadDataM = read_data_r;
    assign BusErrM   = bus_err_r;
    assign StallM    = start_s || (state_r == BUSY);
    assign ExcM      = exc_s;

endmodule
